// File: rtl/rv_dmem2p_pkg.sv
// Shared access-size encoding and alignment/lane helpers for the two-port memory.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  // Halves need an even address, words a multiple of four; size 2'b11 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic res;
    case (size)
      MEM_B:   res = 1'b0;
      MEM_H:   res = addr[0];
      MEM_W:   res = (addr != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << addr;
      MEM_H:   be = addr[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/rv_dmem2p_if.sv
// Request/response signals of the data (D) and fetch (I) ports of rv_dmem2p.
interface rv_dmem2p_if #(parameter int AW = 10);
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic          d_uns;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          i_err;

  modport master (
    output d_req, d_we, d_size, d_uns, d_addr, d_wdata, i_req, i_addr,
    input  d_rvalid, d_rdata, d_err, i_rvalid, i_rdata, i_err
  );

  modport slave (
    input  d_req, d_we, d_size, d_uns, d_addr, d_wdata, i_req, i_addr,
    output d_rvalid, d_rdata, d_err, i_rvalid, i_rdata, i_err
  );
endinterface

// File: rtl/rv_load_align.sv
// Right-justifies the addressed byte/half of a word and sign- or zero-extends it.
module rv_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] sh_s;

  assign sh_s = word_i >> {off_i, 3'b000};

  // Extension selected by access size; illegal sizes produce zero
  always_comb begin
    data_o = 32'h0000_0000;
    case (size_i)
      MEM_B:   data_o = uns_i ? {24'h00_0000, sh_s[7:0]}  : {{24{sh_s[7]}}, sh_s[7:0]};
      MEM_H:   data_o = uns_i ? {16'h0000, sh_s[15:0]}    : {{16{sh_s[15]}}, sh_s[15:0]};
      MEM_W:   data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv_dmem2p.sv
// Two-port byte-addressable memory: D port load/store with lane enables, I port word fetch,
// both with one-cycle registered responses.
module rv_dmem2p
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEMSIZE = 'h400
) (
  input  logic         clk,
  input  logic         reset,
  rv_dmem2p_if.slave   bus
);

  localparam int AW = $clog2(MEMSIZE);
  localparam int NW = MEMSIZE / 4;

  logic [31:0]   mem_q [NW];
  logic [AW-3:0] d_idx_s;
  logic [AW-3:0] i_idx_s;
  logic [31:0]   d_word_s;
  logic [31:0]   d_load_s;
  logic          d_mis_s;
  logic          i_mis_s;
  logic [3:0]    d_be_s;
  logic [31:0]   d_wlane_s;

  logic          d_rvalid_d, d_rvalid_q;
  logic [31:0]   d_rdata_d,  d_rdata_q;
  logic          d_err_d,    d_err_q;
  logic          i_rvalid_d, i_rvalid_q;
  logic [31:0]   i_rdata_d,  i_rdata_q;
  logic          i_err_d,    i_err_q;

  assign d_idx_s  = bus.d_addr[AW-1:2];
  assign i_idx_s  = bus.i_addr[AW-1:2];
  assign d_word_s = mem_q[d_idx_s];
  assign d_mis_s  = misaligned(bus.d_size, bus.d_addr[1:0]);
  assign i_mis_s  = (bus.i_addr[1:0] != 2'b00);

  rv_load_align u_align (
    .word_i (d_word_s),
    .off_i  (bus.d_addr[1:0]),
    .size_i (bus.d_size),
    .uns_i  (bus.d_uns),
    .data_o (d_load_s)
  );

  // Store data replicated across lanes so each enabled lane picks its own slice
  always_comb begin
    d_wlane_s = 32'h0000_0000;
    d_be_s    = 4'b0000;
    if (bus.d_req && bus.d_we && !d_mis_s) begin
      d_be_s = byte_en(bus.d_size, bus.d_addr[1:0]);
    end else begin
      d_be_s = 4'b0000;
    end
    case (bus.d_size)
      MEM_B:   d_wlane_s = {4{bus.d_wdata[7:0]}};
      MEM_H:   d_wlane_s = {2{bus.d_wdata[15:0]}};
      MEM_W:   d_wlane_s = bus.d_wdata;
      default: d_wlane_s = 32'h0000_0000;
    endcase
  end

  // Next response values; reads see the array before this edge's store (read-before-write)
  always_comb begin
    d_rvalid_d = bus.d_req;
    d_err_d    = bus.d_req && d_mis_s;
    i_rvalid_d = bus.i_req;
    i_err_d    = bus.i_req && i_mis_s;
    if (bus.d_req && !bus.d_we && !d_mis_s) begin
      d_rdata_d = d_load_s;
    end else begin
      d_rdata_d = 32'h0000_0000;
    end
    if (bus.i_req && !i_mis_s) begin
      i_rdata_d = mem_q[i_idx_s];
    end else begin
      i_rdata_d = 32'h0000_0000;
    end
  end

  // Storage array; contents deliberately not reset, requests during reset are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (d_be_s[k]) begin
          mem_q[d_idx_s][8*k +: 8] <= d_wlane_s[8*k +: 8];
        end
      end
    end
  end

  // Response registers for both ports
  always_ff @(posedge clk) begin
    if (reset) begin
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= 32'h0000_0000;
      d_err_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'h0000_0000;
      i_err_q    <= 1'b0;
    end else begin
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
      i_rvalid_q <= i_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      i_err_q    <= i_err_d;
    end
  end

  assign bus.d_rvalid = d_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_err    = d_err_q;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_err    = i_err_q;

endmodule

// File: tb/tb_rv_dmem2p.sv
// Self-checking bench for rv_dmem2p: directed scenarios plus random traffic against a byte-array model.
module tb_rv_dmem2p;

  localparam int MEMSIZE = 'h400;
  localparam int AW      = 10;

  logic clk = 1'b0;
  logic reset;

  rv_dmem2p_if #(.AW(AW)) bus ();

  rv_dmem2p #(.MEMSIZE(MEMSIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [MEMSIZE];
  logic        exp_d_rvalid, exp_d_err, exp_i_rvalid, exp_i_err;
  logic [31:0] exp_d_rdata, exp_i_rdata;

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic ref_bad(input int size, input int a);
    if (size == 3) return 1'b1;
    return (a % (1 << size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int size, input logic uns, input int a);
    int v;
    case (size)
      0: begin
        v = int'(ref_mem[a]);
        if (!uns && v >= 128) v = v - 256;
      end
      1: begin
        v = int'(ref_mem[a]) + 256 * int'(ref_mem[a+1]);
        if (!uns && v >= 32768) v = v - 65536;
      end
      default: return ref_word(a);
    endcase
    return 32'(v);
  endfunction

  // Drives one request cycle, predicts the response visible after the edge, then advances.
  task automatic drive(input logic rst, input logic dreq, input logic dwe, input logic [1:0] dsize,
                       input logic duns, input int daddr, input logic [31:0] dwdata,
                       input logic ireq, input int iaddr);
    logic bad;
    reset       = rst;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_size  = dsize;
    bus.d_uns   = duns;
    bus.d_addr  = AW'(daddr);
    bus.d_wdata = dwdata;
    bus.i_req   = ireq;
    bus.i_addr  = AW'(iaddr);
    exp_d_rvalid = 1'b0; exp_d_err = 1'b0; exp_d_rdata = 32'h0;
    exp_i_rvalid = 1'b0; exp_i_err = 1'b0; exp_i_rdata = 32'h0;
    if (!rst) begin
      exp_i_rvalid = ireq;
      exp_i_err    = ireq && (iaddr % 4 != 0);
      if (ireq && iaddr % 4 == 0) exp_i_rdata = ref_word(iaddr);
      bad          = ref_bad(int'(dsize), daddr);
      exp_d_rvalid = dreq;
      exp_d_err    = dreq && bad;
      if (dreq && !dwe && !bad) exp_d_rdata = ref_load(int'(dsize), duns, daddr);
      if (dreq && dwe && !bad)
        for (int k = 0; k < (1 << dsize); k++) ref_mem[daddr+k] = 8'(dwdata >> (8*k));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid got %b want 0", bus.d_rvalid); end
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got %h want 0", bus.d_rdata); end
    checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL rst_d_err got %b want 0", bus.d_err); end
    checks++; if (bus.i_rvalid !== 1'b0) begin errors++; $display("FAIL rst_i_rvalid got %b want 0", bus.i_rvalid); end
    checks++; if (bus.i_rdata !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got %h want 0", bus.i_rdata); end
    checks++; if (bus.i_err !== 1'b0) begin errors++; $display("FAIL rst_i_err got %b want 0", bus.i_err); end
    // Clear the whole array so later reads are defined
    for (int w = 0; w < MEMSIZE / 4; w++) drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 4*w, 32'h0, 1'b0, 0);
    idle();
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL idle_d_rvalid got %b want 0", bus.d_rvalid); end
  endtask

  task automatic test_store_load();
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, 1'b0, 0);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0) begin
      errors++; $display("FAIL store_resp got v=%b d=%h e=%b want 1/0/0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF || bus.d_err !== 1'b0) begin
      errors++; $display("FAIL word_load got v=%b d=%h e=%b want 1/deadbeef/0", bus.d_rvalid, bus.d_rdata, bus.d_err); end
    idle();
    checks++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL one_cycle_rvalid got v=%b d=%h want 0/0", bus.d_rvalid, bus.d_rdata); end
  endtask

  task automatic test_byte_half();
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 'h13, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got %h want ffffffde", bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 'h13, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'h000000DE) begin errors++; $display("FAIL lbu got %h want 000000de", bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 'h10, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh got %h want ffffbeef", bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 'h11, 32'h0000005A, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'hDEAD5AEF) begin errors++; $display("FAIL sb_merge got %h want dead5aef", bus.d_rdata); end
  endtask

  task automatic test_misaligned();
    drive(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 'h13, 32'h0000FFFF, 1'b0, 0);
    checks++; if (bus.d_err !== 1'b1 || bus.d_rvalid !== 1'b1) begin
      errors++; $display("FAIL sh_misal got e=%b v=%b want 1/1", bus.d_err, bus.d_rvalid); end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'hDEAD5AEF) begin errors++; $display("FAIL misal_nowrite got %h want dead5aef", bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h12, 32'h0, 1'b0, 0);
    checks++; if (bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL lw_misal got e=%b d=%h want 1/0", bus.d_err, bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 'h10, 32'h0, 1'b0, 0);
    checks++; if (bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL size11 got e=%b d=%h want 1/0", bus.d_err, bus.d_rdata); end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b1, 'h12);
    checks++; if (bus.i_err !== 1'b1 || bus.i_rdata !== 32'h0 || bus.i_rvalid !== 1'b1) begin
      errors++; $display("FAIL fetch_misal got e=%b d=%h v=%b want 1/0/1", bus.i_err, bus.i_rdata, bus.i_rvalid); end
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 'h20, 32'h11223344, 1'b1, 'h20);
    checks++; if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h0 || bus.i_err !== 1'b0) begin
      errors++; $display("FAIL collide_old got v=%b d=%h e=%b want 1/0/0", bus.i_rvalid, bus.i_rdata, bus.i_err); end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b1, 'h20);
    checks++; if (bus.i_rdata !== 32'h11223344) begin errors++; $display("FAIL collide_new got %h want 11223344", bus.i_rdata); end
  endtask

  task automatic test_reset_behaviour();
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b1, 'h10);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0) begin
      errors++; $display("FAIL squash got dv=%b iv=%b want 0/0", bus.d_rvalid, bus.i_rvalid); end
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 'h30, 32'hCAFEF00D, 1'b1, 'h30);
    checks++; if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0) begin
      errors++; $display("FAIL drop_in_reset got dv=%b iv=%b want 0/0", bus.d_rvalid, bus.i_rvalid); end
    idle();
    checks++; if (bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL post_reset_rvalid got %b want 0", bus.d_rvalid); end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h30, 32'h0, 1'b0, 0);
    checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_store_dropped got %h want 0", bus.d_rdata); end
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b1, 'h20);
    checks++; if (bus.d_rdata !== 32'hDEAD5AEF || bus.i_rdata !== 32'h11223344) begin
      errors++; $display("FAIL survive_reset got d=%h i=%h want dead5aef/11223344", bus.d_rdata, bus.i_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
            1'($urandom_range(1, 0)), int'($urandom_range(63, 0)), $urandom,
            1'($urandom_range(1, 0)), int'($urandom_range(63, 0)));
      checks++;
      if (bus.d_rvalid !== exp_d_rvalid || bus.d_rdata !== exp_d_rdata || bus.d_err !== exp_d_err) begin
        errors++; $display("FAIL rand_d[%0d] got v=%b d=%h e=%b want v=%b d=%h e=%b", n,
          bus.d_rvalid, bus.d_rdata, bus.d_err, exp_d_rvalid, exp_d_rdata, exp_d_err); end
      checks++;
      if (bus.i_rvalid !== exp_i_rvalid || bus.i_rdata !== exp_i_rdata || bus.i_err !== exp_i_err) begin
        errors++; $display("FAIL rand_i[%0d] got v=%b d=%h e=%b want v=%b d=%h e=%b", n,
          bus.i_rvalid, bus.i_rdata, bus.i_err, exp_i_rvalid, exp_i_rdata, exp_i_err); end
    end
  endtask

  initial begin
    for (int a = 0; a < MEMSIZE; a++) ref_mem[a] = 8'h00;
    reset = 1'b1;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_uns = 1'b0;
    bus.d_addr = '0; bus.d_wdata = 32'h0; bus.i_req = 1'b0; bus.i_addr = '0;
    test_reset();
    test_store_load();
    test_byte_half();
    test_misaligned();
    test_collision();
    test_reset_behaviour();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
